axi_slv_mem: RTL and testbench

//  AXI slave (responder) memory model: accepts AW/W bursts, returns B; accepts AR, returns R bursts.

---
 rtl/axi_slv_mem.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_slv_mem.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slv_mem.sv
// ----------------------------------------------------------------------------
// axi_slv_mem
//   AXI responder memory model. Accepts one AW/W write burst at a time and
//   answers with B. Accepts one AR read burst at a time and answers with R
//   beats. The write and read channels run independently. Only full-width
//   beats are supported. FIXED, INCR and WRAP bursts are handled. A WRAP burst
//   whose length is not 2/4/8/16 beats steps like INCR.
//
// Parameters
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  data bus width; one beat = DATA_WIDTH/8 bytes
//   MEM_DEPTH   number of memory words (minimum 2)
//
// Ports
//   ACLK, ARESETn                     clock, synchronous active-low reset
//   AW_ADDR_q/AW_ID/AW_LEN/AW_BURST   write address channel (AWVALID/AWREADY)
//   W_DATA/W_STRB/W_LAST              write data channel (WVALID/WREADY)
//   B_ID/B_RESP                       write response channel (BVALID/BREADY)
//   AR_ADDR_q/AR_ID/AR_LEN/AR_BURST   read address channel (AR_VALID/AR_READY)
//   R_ID/R_DATA/R_RESP/R_LAST         read data channel (RVALID/RREADY)
//
// Configuration macro
//   AXI_SLV_SLVERR_EN  defined: a word index >= MEM_DEPTH is not written,
//                      reads of it return 0, and the response is SLVERR.
//                      undefined: the word index wraps modulo MEM_DEPTH and
//                      the response is OKAY.
// ----------------------------------------------------------------------------
module axi_slv_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AW_ADDR_q,
  input  logic [3:0]              AW_ID,
  input  logic [3:0]              AW_LEN,
  input  logic [1:0]              AW_BURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   W_DATA,
  input  logic [DATA_WIDTH/8-1:0] W_STRB,
  input  logic                    W_LAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [3:0]              B_ID,
  output logic [1:0]              B_RESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   AR_ADDR_q,
  input  logic [3:0]              AR_ID,
  input  logic [3:0]              AR_LEN,
  input  logic [1:0]              AR_BURST,
  input  logic                    AR_VALID,
  output logic                    AR_READY,
  output logic [3:0]              R_ID,
  output logic [DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]              R_RESP,
  output logic                    R_LAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(BYTES);
  localparam int WORD_W = ADDR_WIDTH - OFFS;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(MEM_DEPTH);

`ifdef AXI_SLV_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {WS_IDLE, WS_DATA, WS_RESP} w_state_t;
  typedef enum logic       {RS_IDLE, RS_DATA}          r_state_t;

  // Address of the beat that follows 'addr' in a burst.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [3:0]            len,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = addr + ADDR_WIDTH'(BYTES);
    // The wrap window is (len+1) beats, aligned to its own size.
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << OFFS) - ADDR_WIDTH'(1);
    next_addr = incr;
    if (burst == BURST_FIXED)
      next_addr = addr;
    else if (burst == BURST_WRAP && (len inside {4'd1, 4'd3, 4'd7, 4'd15}))
      next_addr = (addr & ~mask) | (incr & mask);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [WORD_W-1:0] word;
    word = addr[ADDR_WIDTH-1:OFFS];
    word_idx = IDX_W'(word % DEPTH_W);
  endfunction

  function automatic logic word_oob(input logic [ADDR_WIDTH-1:0] addr);
    word_oob = SLVERR_EN && (addr[ADDR_WIDTH-1:OFFS] >= DEPTH_W);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write FSM
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_len;
  logic [1:0]            wr_burst;
  logic [3:0]            wr_beat;
  logic                  wr_err;
  logic                  wr_fire;
  logic                  wr_last_beat;
  logic                  wr_beat_err;

  assign wr_fire      = (w_state == WS_DATA) && WVALID && WREADY;
  assign wr_last_beat = (wr_beat == wr_len);
  assign wr_beat_err  = (W_LAST != wr_last_beat) || word_oob(wr_addr);

  // NOTE: state registers use non-blocking assignments, so every read inside
  // the block sees the value from before this edge.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      w_state  <= WS_IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      B_ID     <= '0;
      B_RESP   <= RESP_OKAY;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_burst <= BURST_FIXED;
      wr_beat  <= '0;
      wr_err   <= 1'b0;
    end else begin
      case (w_state)
        WS_IDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
            wr_addr  <= AW_ADDR_q;
            wr_len   <= AW_LEN;
            wr_burst <= AW_BURST;
            B_ID     <= AW_ID;
            wr_beat  <= '0;
            wr_err   <= (AW_BURST == BURST_RSVD);
            w_state  <= WS_DATA;
          end
        end
        WS_DATA: begin
          if (wr_fire) begin
            wr_addr <= next_addr(wr_addr, wr_len, wr_burst);
            wr_beat <= wr_beat + 4'd1;
            if (wr_beat_err) wr_err <= 1'b1;
            // The burst length comes from AW_LEN; W_LAST is only checked.
            if (wr_last_beat) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              B_RESP  <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state <= WS_RESP;
            end
          end
        end
        WS_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= WS_IDLE;
          end
        end
        default: w_state <= WS_IDLE;
      endcase
    end
  end

  // NOTE: the memory array has no reset, so its contents survive ARESETn.
  always_ff @(posedge ACLK) begin
    if (ARESETn && wr_fire && !word_oob(wr_addr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (W_STRB[b]) mem[word_idx(wr_addr)][8*b +: 8] <= W_DATA[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [3:0]            rd_len;
  logic [1:0]            rd_burst;
  logic [3:0]            rd_beat;

  // Data for one read beat. A write to the same word on the same edge is not
  // visible yet, so a read returns the data from before that write.
  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [1:0]            burst);
    beat_data = (burst == BURST_RSVD || word_oob(addr)) ? '0 : mem[word_idx(addr)];
  endfunction

  function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [1:0]            burst);
    beat_resp = (burst == BURST_RSVD || word_oob(addr)) ? RESP_SLVERR : RESP_OKAY;
  endfunction

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state  <= RS_IDLE;
      AR_READY <= 1'b0;
      RVALID   <= 1'b0;
      R_LAST   <= 1'b0;
      R_ID     <= '0;
      R_DATA   <= '0;
      R_RESP   <= RESP_OKAY;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_burst <= BURST_FIXED;
      rd_beat  <= '0;
    end else begin
      case (r_state)
        RS_IDLE: begin
          AR_READY <= 1'b1;
          if (AR_VALID && AR_READY) begin
            // Beat 0 is loaded straight away, so RVALID rises on the next edge.
            AR_READY <= 1'b0;
            rd_len   <= AR_LEN;
            rd_burst <= AR_BURST;
            rd_addr  <= next_addr(AR_ADDR_q, AR_LEN, AR_BURST);
            rd_beat  <= '0;
            R_ID     <= AR_ID;
            R_DATA   <= beat_data(AR_ADDR_q, AR_BURST);
            R_RESP   <= beat_resp(AR_ADDR_q, AR_BURST);
            R_LAST   <= (AR_LEN == 4'd0);
            RVALID   <= 1'b1;
            r_state  <= RS_DATA;
          end
        end
        RS_DATA: begin
          if (RREADY) begin
            if (R_LAST) begin
              RVALID   <= 1'b0;
              R_LAST   <= 1'b0;
              AR_READY <= 1'b1;
              r_state  <= RS_IDLE;
            end else begin
              R_DATA  <= beat_data(rd_addr, rd_burst);
              R_RESP  <= beat_resp(rd_addr, rd_burst);
              R_LAST  <= (rd_beat + 4'd1 == rd_len);
              rd_beat <= rd_beat + 4'd1;
              rd_addr <= next_addr(rd_addr, rd_len, rd_burst);
            end
          end
        end
        default: r_state <= RS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// ----------------------------------------------------------------------------
// tb_axi_slv_mem
//   Directed bench for axi_slv_mem. Expected B and R results are queued when a
//   burst is issued and are compared when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_axi_slv_mem;

  localparam int TMO = 50;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam logic [1:0] RSVD   = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AW_ADDR_q;
  logic [3:0]  AW_ID, AW_LEN;
  logic [1:0]  AW_BURST;
  logic        AWVALID, AWREADY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        W_LAST, WVALID, WREADY;
  logic [3:0]  B_ID;
  logic [1:0]  B_RESP;
  logic        BVALID, BREADY;
  logic [31:0] AR_ADDR_q;
  logic [3:0]  AR_ID, AR_LEN;
  logic [1:0]  AR_BURST;
  logic        AR_VALID, AR_READY;
  logic [3:0]  R_ID;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_LAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AW_ADDR_q(AW_ADDR_q), .AW_ID(AW_ID), .AW_LEN(AW_LEN), .AW_BURST(AW_BURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST), .WVALID(WVALID), .WREADY(WREADY),
    .B_ID(B_ID), .B_RESP(B_RESP), .BVALID(BVALID), .BREADY(BREADY),
    .AR_ADDR_q(AR_ADDR_q), .AR_ID(AR_ID), .AR_LEN(AR_LEN), .AR_BURST(AR_BURST),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_ID(R_ID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [31:0] wdat [16];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expired(input string tag);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: observed no DUT event within %0d cycles, expected one", tag, TMO);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_r(input logic [31:0] d, input logic [3:0] id, input logic [1:0] resp,
                        input logic last);
    r_exp_t e;
    e.data = d; e.id = id; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  // Full write burst; early_last marks a beat that carries a premature W_LAST.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int early_last,
                          input logic [1:0] resp, input int hold);
    b_exp_t e;
    int     n;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
    AW_ADDR_q = addr; AW_ID = id; AW_LEN = len; AW_BURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) expired("aw_handshake");
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      W_DATA = wdat[i]; W_STRB = strb; W_LAST = (i == int'(len)) || (i == early_last);
      WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < TMO) begin tick(); n++; end
      if (n >= TMO) expired("w_handshake");
      tick();
    end
    WVALID = 1'b0; W_LAST = 1'b0;
    n = 0;
    while (BVALID !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) expired("b_valid");
    e = exp_b.pop_front();
    for (int c = 0; c < hold; c++) begin
      tick();
      check("b_valid_held", BVALID, 1'b1);
      check("b_resp_held", B_RESP, e.resp);
    end
    check("b_id", B_ID, e.id);
    check("b_resp", B_RESP, e.resp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("b_valid_drop", BVALID, 1'b0);
    check("awready_after_b", AWREADY, 1'b1);
  endtask

  // Read burst; expected beats must already be queued. RREADY is dropped for
  // stall_cyc cycles while beat stall_beat is presented.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                         input logic [1:0] burst, input int stall_beat, input int stall_cyc);
    r_exp_t e;
    int     n;
    AR_ADDR_q = addr; AR_ID = id; AR_LEN = len; AR_BURST = burst; AR_VALID = 1'b1;
    n = 0;
    while (AR_READY !== 1'b1 && n < TMO) begin tick(); n++; end
    if (n >= TMO) expired("ar_handshake");
    tick();
    AR_VALID = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (RVALID !== 1'b1 && n < TMO) begin tick(); n++; end
      if (n >= TMO) expired("r_valid");
      if (exp_r.size() == 0) begin
        expired("r_scoreboard_empty");
        break;
      end
      e = exp_r.pop_front();
      if (i == stall_beat) begin
        RREADY = 1'b0;
        for (int c = 0; c < stall_cyc; c++) begin
          tick();
          check("r_stall_valid", RVALID, 1'b1);
          check("r_stall_data", R_DATA, e.data);
          check("r_stall_last", R_LAST, e.last);
        end
        RREADY = 1'b1;
      end
      check("r_data", R_DATA, e.data);
      check("r_id", R_ID, e.id);
      check("r_resp", R_RESP, e.resp);
      check("r_last", R_LAST, e.last);
      tick();
    end
    RREADY = 1'b0;
    check("r_valid_drop", RVALID, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESETn = 1'b0;
    AW_ADDR_q = '0; AW_ID = '0; AW_LEN = '0; AW_BURST = '0; AWVALID = 1'b0;
    W_DATA = '0; W_STRB = '0; W_LAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    AR_ADDR_q = '0; AR_ID = '0; AR_LEN = '0; AR_BURST = '0; AR_VALID = 1'b0; RREADY = 1'b0;
    repeat (3) tick();

    // Reset state: every output low.
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_arready", AR_READY, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rlast", R_LAST, 1'b0);
    ARESETn = 1'b1;
    tick();
    check("rel_awready", AWREADY, 1'b1);
    check("rel_arready", AR_READY, 1'b1);

    // INCR write of four beats at 0x10 with BREADY held low for 3 cycles, then
    // read back with RREADY low for 5 cycles on the second beat.
    wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2; wdat[3] = 32'hA3;
    do_write(32'h10, 4'd3, 4'd3, INCR, 4'hF, -1, OKAY, 3);
    push_r(32'hA0, 4'd3, OKAY, 1'b0);
    push_r(32'hA1, 4'd3, OKAY, 1'b0);
    push_r(32'hA2, 4'd3, OKAY, 1'b0);
    push_r(32'hA3, 4'd3, OKAY, 1'b1);
    do_read(32'h10, 4'd3, 4'd3, INCR, 1, 5);

    // WRAP of four beats from 0x08 fills words 0x08, 0x0C, 0x00, 0x04.
    wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'd4;
    do_write(32'h08, 4'd1, 4'd3, WRAP, 4'hF, -1, OKAY, 0);
    push_r(32'd3, 4'd2, OKAY, 1'b0);
    push_r(32'd4, 4'd2, OKAY, 1'b0);
    push_r(32'd1, 4'd2, OKAY, 1'b0);
    push_r(32'd2, 4'd2, OKAY, 1'b1);
    do_read(32'h00, 4'd2, 4'd3, INCR, -1, 0);
    push_r(32'd1, 4'd5, OKAY, 1'b0);
    push_r(32'd2, 4'd5, OKAY, 1'b0);
    push_r(32'd3, 4'd5, OKAY, 1'b0);
    push_r(32'd4, 4'd5, OKAY, 1'b1);
    do_read(32'h08, 4'd5, 4'd3, WRAP, -1, 0);

    // Byte strobes: low two bytes of all-ones over a zero word.
    wdat[0] = 32'h0;
    do_write(32'h20, 4'd4, 4'd0, INCR, 4'hF, -1, OKAY, 0);
    wdat[0] = 32'hFFFF_FFFF;
    do_write(32'h20, 4'd4, 4'd0, INCR, 4'b0011, -1, OKAY, 0);
    push_r(32'h0000_FFFF, 4'd4, OKAY, 1'b1);
    do_read(32'h20, 4'd4, 4'd0, INCR, -1, 0);

    // FIXED burst keeps hitting one word; the last beat wins.
    wdat[0] = 32'h5; wdat[1] = 32'h6;
    do_write(32'h40, 4'd7, 4'd1, FIXED, 4'hF, -1, OKAY, 0);
    push_r(32'h6, 4'd7, OKAY, 1'b0);
    push_r(32'h6, 4'd7, OKAY, 1'b1);
    do_read(32'h40, 4'd7, 4'd1, FIXED, -1, 0);

    // Protocol errors: early W_LAST on beat 2, and the reserved burst type.
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    do_write(32'h80, 4'd8, 4'd3, INCR, 4'hF, 1, SLVERR, 0);
    do_write(32'h90, 4'd9, 4'd0, RSVD, 4'hF, -1, SLVERR, 0);
    push_r(32'h0, 4'd10, SLVERR, 1'b0);
    push_r(32'h0, 4'd10, SLVERR, 1'b1);
    do_read(32'h10, 4'd10, 4'd1, RSVD, -1, 0);

    // Reset during beat 2 of a 4-beat write: no B, readies return after release.
    AW_ADDR_q = 32'h100; AW_ID = 4'd11; AW_LEN = 4'd3; AW_BURST = INCR; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("abort_wready", WREADY, 1'b1);
    W_DATA = 32'h77; W_STRB = 4'hF; W_LAST = 1'b0; WVALID = 1'b1;
    tick();
    ARESETn = 1'b0;
    tick();
    WVALID = 1'b0;
    check("abort_awready", AWREADY, 1'b0);
    check("abort_wready_rst", WREADY, 1'b0);
    check("abort_bvalid", BVALID, 1'b0);
    check("abort_arready", AR_READY, 1'b0);
    check("abort_rvalid", RVALID, 1'b0);
    ARESETn = 1'b1;
    tick();
    check("abort_awready_rel", AWREADY, 1'b1);
    check("abort_arready_rel", AR_READY, 1'b1);
    repeat (2) tick();
    check("abort_no_b", BVALID, 1'b0);

    // Memory survives reset.
    push_r(32'hA0, 4'd12, OKAY, 1'b1);
    do_read(32'h10, 4'd12, 4'd0, INCR, -1, 0);

    // Word index MEM_DEPTH (byte address 0x1000).
    wdat[0] = 32'hDEAD_BEEF;
`ifdef AXI_SLV_SLVERR_EN
    do_write(32'h1000, 4'd6, 4'd0, INCR, 4'hF, -1, SLVERR, 0);
    push_r(32'd3, 4'd6, OKAY, 1'b1);
`else
    do_write(32'h1000, 4'd6, 4'd0, INCR, 4'hF, -1, OKAY, 0);
    push_r(32'hDEAD_BEEF, 4'd6, OKAY, 1'b1);
`endif
    do_read(32'h0, 4'd6, 4'd0, INCR, -1, 0);

    check("exp_b_drained", exp_b.size(), 0);
    check("exp_r_drained", exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
